// File: rtl/modexp_ctrl.sv
// Purpose: left-to-right square-and-multiply controller for Montgomery modular exponentiation.
// Latency: (k + popcount + 1) multiplier round trips plus 3 cycles (capture, DONE, return to IDLE).
// Backpressure: one operation at a time; start is only honoured in IDLE, and the multiplier paces each step.
module modexp_ctrl #(
  parameter int WIDTH = 512,
  parameter int CNTW  = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] msg_mont,
  input  logic [WIDTH-1:0] one_mont,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] exp,
  input  logic [CNTW-1:0]  exp_len,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             mont_start,
  output logic [WIDTH-1:0] mont_a,
  output logic [WIDTH-1:0] mont_b,
  output logic [WIDTH-1:0] mont_m,
  input  logic [WIDTH+1:0] mont_c,
  input  logic             mont_done
);

  // The bit counter has to be able to hold WIDTH itself, the clamp value for exp_len.
  if ((2 ** CNTW) <= WIDTH) begin : g_cntw_check
    $error("modexp_ctrl: CNTW is too narrow to count WIDTH exponent bits");
  end

  // Index width needed to select one bit of the exponent register.
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNTW-1:0]  LP_LEN_MAX = CNTW'(WIDTH);
  localparam logic [CNTW-1:0]  LP_IDX_ONE = CNTW'(1);
  localparam logic [CNTW-1:0]  LP_IDX_ZERO = '0;
  localparam logic [WIDTH-1:0] LP_OPND_ONE = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SQ_START   = 3'd1,
    S_SQ_WAIT    = 3'd2,
    S_MUL_START  = 3'd3,
    S_MUL_WAIT   = 3'd4,
    S_CONV_START = 3'd5,
    S_CONV_WAIT  = 3'd6,
    S_DONE       = 3'd7
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_msg;
  logic [WIDTH-1:0] r_exp;
  logic [CNTW-1:0]  r_idx;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_busy;
  logic             r_mont_start;
  // r_mont_a doubles as the accumulator A: every update of A is also the
  // next multiplier a-operand, so a separate copy would only duplicate it.
  logic [WIDTH-1:0] r_mont_a;
  logic [WIDTH-1:0] r_mont_b;
  logic [WIDTH-1:0] r_mont_m;

  logic [CNTW-1:0]  w_len;
  logic [IDXW-1:0]  w_bit_sel;
  logic             w_exp_bit;
  logic             w_idx_zero;
  logic [WIDTH-1:0] w_prod;
  logic [1:0]       w_unused_c_hi;

  // Exponent length clamped to the operand width.
  assign w_len = (exp_len > LP_LEN_MAX) ? LP_LEN_MAX : exp_len;

  // Current exponent bit; r_idx never exceeds WIDTH-1 so the narrow select is exact.
  assign w_bit_sel = r_idx[IDXW-1:0];
  assign w_exp_bit = r_exp[w_bit_sel];
  assign w_idx_zero = (r_idx == LP_IDX_ZERO);

  // The multiplier returns a fully reduced value; the two guard bits carry nothing.
  assign w_prod        = mont_c[WIDTH-1:0];
  assign w_unused_c_hi = mont_c[WIDTH+1:WIDTH];

  // Controller FSM: every output is a register written here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_msg        <= '0;
      r_exp        <= '0;
      r_idx        <= '0;
      r_result     <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_mont_start <= 1'b0;
      r_mont_a     <= '0;
      r_mont_b     <= '0;
      r_mont_m     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Snapshot every operand so later input changes cannot disturb the run.
            r_msg    <= msg_mont;
            r_exp    <= exp;
            r_mont_m <= m;
            r_busy   <= 1'b1;
            // A starts at one in Montgomery form.
            r_mont_a     <= one_mont;
            r_mont_start <= 1'b1;
            if (w_len != LP_IDX_ZERO) begin
              r_idx    <= w_len - LP_IDX_ONE;
              r_mont_b <= one_mont;
              r_state  <= S_SQ_START;
            end else begin
              // No exponent bits: go straight to the conversion out of Montgomery form.
              r_idx    <= '0;
              r_mont_b <= LP_OPND_ONE;
              r_state  <= S_CONV_START;
            end
          end
        end

        S_SQ_START: begin
          r_mont_start <= 1'b0;
          r_state      <= S_SQ_WAIT;
        end

        S_SQ_WAIT: begin
          if (mont_done) begin
            r_mont_a     <= w_prod;
            r_mont_start <= 1'b1;
            if (w_exp_bit) begin
              // Bit set: fold the base in before moving to the next bit.
              r_mont_b <= r_msg;
              r_state  <= S_MUL_START;
            end else if (w_idx_zero) begin
              r_mont_b <= LP_OPND_ONE;
              r_state  <= S_CONV_START;
            end else begin
              r_mont_b <= w_prod;
              r_idx    <= r_idx - LP_IDX_ONE;
              r_state  <= S_SQ_START;
            end
          end
        end

        S_MUL_START: begin
          r_mont_start <= 1'b0;
          r_state      <= S_MUL_WAIT;
        end

        S_MUL_WAIT: begin
          if (mont_done) begin
            r_mont_a     <= w_prod;
            r_mont_start <= 1'b1;
            if (w_idx_zero) begin
              r_mont_b <= LP_OPND_ONE;
              r_state  <= S_CONV_START;
            end else begin
              r_mont_b <= w_prod;
              r_idx    <= r_idx - LP_IDX_ONE;
              r_state  <= S_SQ_START;
            end
          end
        end

        S_CONV_START: begin
          r_mont_start <= 1'b0;
          r_state      <= S_CONV_WAIT;
        end

        S_CONV_WAIT: begin
          // Multiplying by plain 1 strips the R factor, leaving the normal-form result.
          if (mont_done) begin
            r_result <= w_prod;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_mont_start <= 1'b0;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign result     = r_result;
  assign done       = r_done;
  assign busy       = r_busy;
  assign mont_start = r_mont_start;
  assign mont_a     = r_mont_a;
  assign mont_b     = r_mont_b;
  assign mont_m     = r_mont_m;

endmodule

// File: tb/tb_modexp_ctrl.sv
module tb_modexp_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int R  = 256;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  msg_mont = '0;
  logic [W-1:0]  one_mont = '0;
  logic [W-1:0]  m = '0;
  logic [W-1:0]  exp = '0;
  logic [CW-1:0] exp_len = '0;
  logic [W-1:0]  result;
  logic          done;
  logic          busy;
  logic          mont_start;
  logic [W-1:0]  mont_a;
  logic [W-1:0]  mont_b;
  logic [W-1:0]  mont_m;
  logic [W+1:0]  mont_c;
  logic          mont_done;

  logic          mdl_done = 1'b0;
  logic [W+1:0]  mdl_c = '0;
  logic          spur = 1'b0;

  // A spurious completion carries a garbage product so any wrongful capture shows up.
  assign mont_done = mdl_done | spur;
  assign mont_c    = spur ? 10'h2A5 : mdl_c;

  modexp_ctrl #(.WIDTH(W), .CNTW(CW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .msg_mont   (msg_mont),
    .one_mont   (one_mont),
    .m          (m),
    .exp        (exp),
    .exp_len    (exp_len),
    .result     (result),
    .done       (done),
    .busy       (busy),
    .mont_start (mont_start),
    .mont_a     (mont_a),
    .mont_b     (mont_b),
    .mont_m     (mont_m),
    .mont_c     (mont_c),
    .mont_done  (mont_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: one entry per accepted operation.
  int    q_res[$];
  int    q_pulses[$];
  int    q_m[$];
  longint q_sqmask[$];

  task automatic chk(string name, longint act, longint req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int modpow(int x, int e, int mm);
    int r;
    int b;
    r = 1 % mm;
    b = x % mm;
    for (int k = 0; k < 16; k++) begin
      if (e[k]) r = (r * b) % mm;
      b = (b * b) % mm;
    end
    return r;
  endfunction

  function automatic int inv_r(int mm);
    for (int r = 1; r < mm; r++)
      if (((R * r) % mm) == 1) return r;
    return 0;
  endfunction

  // Behavioural Montgomery multiplier: a*b*R^-1 mod m, answer 5 cycles after the request.
  initial begin
    int mcnt;
    int pend;
    int mm;
    mcnt = 0;
    pend = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mcnt     = 0;
        mdl_done = 1'b0;
      end else begin
        mdl_done = 1'b0;
        if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0) begin
            mdl_done = 1'b1;
            mdl_c    = (W+2)'(pend);
          end
        end
        if (mont_start) begin
          mm   = int'(mont_m);
          pend = (mm > 0) ? ((int'(mont_a) * int'(mont_b) % mm) * inv_r(mm)) % mm : 0;
          mcnt = 5;
        end
      end
    end
  end

  // Monitor: counts multiplier requests and checks each completed operation.
  initial begin
    int  cnt;
    bit  prev_done;
    int  last_b;
    longint sm;
    cnt = 0;
    prev_done = 1'b0;
    last_b = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        cnt = 0;
        prev_done = 1'b0;
      end else begin
        if (mont_start) begin
          if (q_res.size() == 0) begin
            chk("unexpected_mont_start", 1, 0);
          end else begin
            chk("mont_m_captured", mont_m, q_m[0]);
            sm = q_sqmask[0];
            if (cnt < 64 && sm[cnt]) chk("square_a_eq_b", mont_a, mont_b);
          end
          last_b = int'(mont_b);
          cnt++;
        end
        if (done) begin
          chk("done_single_cycle", prev_done, 0);
          chk("busy_at_done", busy, 1);
          if (q_res.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            chk("result", result, q_res.pop_front());
            chk("mont_start_count", cnt, q_pulses.pop_front());
            chk("conv_b_is_one", last_b, 1);
            void'(q_m.pop_front());
            void'(q_sqmask.pop_front());
          end
          cnt = 0;
        end
        prev_done = done;
      end
    end
  end

  // Drive one start request (called at a negedge) and record what it must produce.
  task automatic issue(int x, int mm, int e, int len);
    int le;
    int em;
    int k;
    longint mask;
    le = (len > W) ? W : len;
    em = e & ((1 << le) - 1);
    mask = 0;
    k = 0;
    for (int b = le - 1; b >= 0; b--) begin
      mask[k] = 1'b1;
      k++;
      if (em[b]) k++;
    end
    q_res.push_back(modpow(x, em, mm));
    q_pulses.push_back(le + $countones(em) + 1);
    q_m.push_back(mm);
    q_sqmask.push_back(mask);
    msg_mont = W'((x * R) % mm);
    one_mont = W'(R % mm);
    m        = W'(mm);
    exp      = W'(e);
    exp_len  = CW'(len);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 3000);
    if (!done) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int seen;
    int t;
    int mm;
    int x;

    repeat (3) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mont_start", mont_start, 0);
    chk("rst_mont_a", mont_a, 0);
    chk("rst_mont_b", mont_b, 0);
    chk("rst_mont_m", mont_m, 0);
    resetn = 1'b1;
    @(negedge clk);

    // 2^5 mod 13 = 6 over six multiplications.
    issue(2, 13, 5, 3);
    chk("busy_after_start", busy, 1);
    wait_done();

    // Zero-length exponent: conversion only.
    issue(2, 13, 8'hFF, 0);
    wait_done();

    // All-zero exponent bits: four squares then conversion.
    issue(2, 13, 0, 4);
    wait_done();

    // Length above WIDTH clamps to WIDTH.
    issue(3, 13, 8'hB7, 15);
    wait_done();

    // A second start during SQ_WAIT, with every input changed, must be ignored.
    issue(2, 13, 5, 3);
    @(negedge clk);
    msg_mont = 8'd77;
    m        = 8'd201;
    exp      = 8'd3;
    exp_len  = 4'd2;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done();

    // Spurious completion while idle.
    spur = 1'b1;
    repeat (2) @(negedge clk);
    spur = 1'b0;
    @(negedge clk);

    // Spurious completion in SQ_START (issue returns with the first request showing).
    issue(2, 13, 5, 3);
    spur = 1'b1;
    @(posedge clk);
    #1 spur = 1'b0;
    wait_done();

    // Reset during MUL_WAIT aborts the run; a new start right after release must be taken.
    issue(2, 13, 5, 3);
    seen = 1;
    t = 0;
    while (seen < 2 && t < 200) begin
      @(negedge clk);
      t++;
      if (mont_start) seen++;
    end
    if (seen < 2) chk("mul_start_timeout", 0, 1);
    @(negedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_mont_start", mont_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    chk("arst_mont_a", mont_a, 0);
    @(negedge clk);
    q_res.delete();
    q_pulses.delete();
    q_m.delete();
    q_sqmask.delete();
    @(negedge clk);
    resetn = 1'b1;
    issue(2, 13, 12, 4);
    wait_done();

    // Randomised operands and moduli.
    for (int n = 0; n < 25; n++) begin
      mm = int'($urandom_range(1, 127)) * 2 + 1;
      x  = int'($urandom_range(0, mm - 1));
      issue(x, mm, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
      wait_done();
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", q_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/modexp_ctrl.md
MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 Parameter WIDTH, default 512, operand width in bits; the Montgomery radix is R = 2^WIDTH.
REQ-002 Parameter CNTW, default 10, width of the exponent bit counter; the design SHALL require 2^CNTW > WIDTH.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset; asynchronous assertion and active-low.
REQ-005 start  input  1  one-cycle request to begin an exponentiation; sampled only in IDLE.
REQ-006 msg_mont  input  WIDTH  base x in Montgomery form (x*R mod m).
REQ-007 one_mont  input  WIDTH  R mod m (one in Montgomery form).
REQ-008 m  input  WIDTH  odd modulus.
REQ-009 exp  input  WIDTH  exponent.
REQ-010 exp_len  input  CNTW  number of exponent bits to process, MSB-first from bit exp_len-1.
REQ-011 result  output  WIDTH  x^exp mod m in normal (non-Montgomery) form.
REQ-012 done  output  1  one-cycle pulse when result becomes valid.
REQ-013 busy  output  1  high from the cycle after an accepted start until the done cycle, inclusive.
REQ-014 mont_start  output  1  one-cycle request to the Montgomery multiplier.
REQ-015 mont_a, mont_b, mont_m  output  WIDTH each  multiplier operands.
REQ-016 mont_c  input  WIDTH+2  multiplier result; the result is already reduced, so only bits [WIDTH-1:0] are used.
REQ-017 mont_done  input  1  multiplier completion; the block treats it as a pulse or a level and acts on its first high cycle in a WAIT state.

Function
REQ-018 States SHALL be IDLE, SQ_START, SQ_WAIT, MUL_START, MUL_WAIT, CONV_START, CONV_WAIT, DONE.
REQ-019 In IDLE with start=1, the block SHALL capture msg_mont, m, exp and min(exp_len, WIDTH) into internal registers, and load accumulator A <= one_mont.
- Next state: SQ_START if the captured length is >0, else CONV_START.
- Bit index i <= length-1.
REQ-020 SQ_START SHALL drive mont_start=1 with mont_a=mont_b=A, then go to SQ_WAIT.
REQ-021 SQ_WAIT on mont_done SHALL set A <= mont_c[WIDTH-1:0].
- Next state: MUL_START if exp_reg[i]=1.
- Else CONV_START if i=0.
- Else SQ_START with i <= i-1.
REQ-022 MUL_START SHALL drive mont_start=1 with mont_a=A and mont_b=msg_reg, then go to MUL_WAIT.
REQ-023 MUL_WAIT on mont_done SHALL set A <= mont_c[WIDTH-1:0].
- Next state: CONV_START if i=0.
- Else SQ_START with i <= i-1.
REQ-024 CONV_START SHALL drive mont_start=1 with mont_a=A and mont_b=1 (zero-extended), then go to CONV_WAIT.
REQ-025 CONV_WAIT on mont_done SHALL load result <= mont_c[WIDTH-1:0] and go to DONE.
REQ-026 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-027 mont_start SHALL be high only in the three *_START states, exactly one cycle per multiplication.
REQ-028 mont_a, mont_b and mont_m SHALL be registered and held stable from the START cycle through the end of the matching WAIT state; mont_m SHALL equal the captured m.
REQ-029 mont_done outside a WAIT state SHALL be ignored.
REQ-030 start while busy SHALL be ignored, with no effect on the captured operands.
REQ-031 result SHALL hold its value until the next CONV_WAIT completion; input changes after capture SHALL not affect the operation in progress.
REQ-032 An exponent with k processed bits and popcount p SHALL issue exactly k+p+1 mont_start pulses.
REQ-033 exp_len > WIDTH SHALL be clamped to WIDTH.
REQ-034 exp_len = 0 SHALL yield a single conversion multiply, giving result = 1 mod m.

Reset
REQ-035 On resetn=0, regardless of state including mid-operation, the block SHALL immediately enter IDLE.
- Output values: done=0, busy=0, mont_start=0, result=0, mont_a=mont_b=mont_m=0.
- Internal registers: A=0, counter=0.
REQ-036 After resetn deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-037 The bench SHALL use WIDTH=8 and a behavioral Montgomery model with latency 5; the vectors are m=13, R mod m=9, msg_mont=5 (x=2).
REQ-038 exp=5, exp_len=3 -> result=6; 6 mont_start pulses; single-cycle done.
REQ-039 exp_len=0, exp=0xFF -> result=1 after exactly 1 mont_start.
REQ-040 exp=0, exp_len=4 -> result=1 after exactly 5 mont_start pulses, with mont_b always equal to mont_a for the first 4.
REQ-041 start pulsed again during SQ_WAIT with different exp -> ignored; result=6 for the original exp=5 operation.
REQ-042 resetn pulsed low during MUL_WAIT -> mont_start, busy and done go low asynchronously; a new start with exp=12, exp_len=4 then yields result 2^12 mod 13 = 1.
REQ-043 Spurious mont_done in IDLE and in SQ_START -> no state change and no A update; the final result is unchanged.
